// File: rtl/game_pkg.sv
// Shared game definitions: tile codes, map controller states and map size defaults.
package game_pkg;

    localparam int MAP_W_DEF  = 64;
    localparam int MAP_H_DEF  = 48;
    localparam int TILE_EMPTY = 0;

    typedef enum logic [1:0] {
        MS_CLEAR,
        MS_IDLE,
        MS_CHECK,
        MS_COMMIT
    } map_state_t;

    function automatic int tile_frame(input int n_players);
        return n_players + 1;
    endfunction

endpackage

// File: rtl/tile_ram.sv
// Tile storage: port A is read/write for the controller, port B is read-only for the renderer.
module tile_ram #(
    parameter int  DEPTH = 3072,
    parameter int  W     = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [W-1:0]  a_wdata,
    output logic [W-1:0]  a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [W-1:0]  b_rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem[a_addr] <= a_wdata;
            end
            a_rdata <= mem[a_addr];
        end
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/tile_map_ctrl.sv
// Tile map owner: bordered sweep, atomic check-and-claim moves, free-running render port.
module tile_map_ctrl
    import game_pkg::*;
#(
    parameter int  MAP_W     = MAP_W_DEF,
    parameter int  MAP_H     = MAP_H_DEF,
    parameter int  N_PLAYERS = 2,
    localparam int TILE_W    = $clog2(N_PLAYERS + 2),
    localparam int XW        = $clog2(MAP_W) + 1,
    localparam int YW        = $clog2(MAP_H) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic [TILE_W-1:0] move_player,
    input  logic [XW-1:0]     move_x,
    input  logic [YW-1:0]     move_y,
    output logic              result_valid,
    output logic              result_hit,
    output logic [TILE_W-1:0] result_tile,
    output logic              result_err,
    input  logic [XW-1:0]     rd_x,
    input  logic [YW-1:0]     rd_y,
    output logic [TILE_W-1:0] rd_tile
);

    localparam int DEPTH = MAP_W * MAP_H;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [TILE_W-1:0] FRAME = TILE_W'(tile_frame(N_PLAYERS));
    localparam logic [TILE_W-1:0] EMPTY = TILE_W'(TILE_EMPTY);

    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                                input logic [YW-1:0] y);
        return AW'(int'(y) * MAP_W + int'(x));
    endfunction

    map_state_t        state_q, state_d;
    logic [XW-1:0]     cx_q, cx_d, tx_q, tx_d;
    logic [YW-1:0]     cy_q, cy_d, ty_q, ty_d;
    logic [TILE_W-1:0] pl_q, pl_d, rtile_q, rtile_d;
    logic              off_q, off_d, pend_q, pend_d;
    logic              busy_q, busy_d, ready_q, ready_d;
    logic              rv_q, rv_d, rhit_q, rhit_d, rerr_q, rerr_d;
    logic              rd_off_q, rd_off_d;

    logic              a_en, a_we;
    logic [AW-1:0]     a_addr, b_addr;
    logic [TILE_W-1:0] a_wdata, a_rdata, b_rdata, occ;
    logic              pl_ok, last_x, last_y, border;

    tile_ram #(
        .DEPTH(DEPTH),
        .W    (TILE_W)
    ) u_ram (
        .clk    (clk),
        .a_en   (a_en && rst),
        .a_we   (a_we),
        .a_addr (a_addr),
        .a_wdata(a_wdata),
        .a_rdata(a_rdata),
        .b_addr (b_addr),
        .b_rdata(b_rdata)
    );

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        pl_d    = pl_q;
        off_d   = off_q;
        pend_d  = pend_q;
        rtile_d = rtile_q;
        rv_d    = 1'b0;
        rhit_d  = 1'b0;
        rerr_d  = 1'b0;
        a_en    = 1'b0;
        a_we    = 1'b0;
        a_addr  = '0;
        a_wdata = EMPTY;
        last_x  = int'(cx_q) == MAP_W - 1;
        last_y  = int'(cy_q) == MAP_H - 1;
        border  = cx_q == '0 || cy_q == '0 || last_x || last_y;
        occ     = off_q ? FRAME : a_rdata;
        pl_ok   = pl_q != '0 && int'(pl_q) <= N_PLAYERS;

        unique case (state_q)
            MS_CLEAR: begin
                a_en    = 1'b1;
                a_we    = 1'b1;
                a_addr  = cell_addr(cx_q, cy_q);
                a_wdata = border ? FRAME : EMPTY;
                if (last_x) begin
                    cx_d = '0;
                    if (last_y) begin
                        cy_d    = '0;
                        state_d = MS_IDLE;
                    end else begin
                        cy_d = cy_q + YW'(1);
                    end
                end else begin
                    cx_d = cx_q + XW'(1);
                end
            end
            MS_IDLE: begin
                // A pending or fresh clear wins over a same-cycle move.
                if (clear_req || pend_q) begin
                    pend_d  = 1'b0;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = MS_CLEAR;
                end else if (move_valid && ready_q) begin
                    tx_d    = move_x;
                    ty_d    = move_y;
                    pl_d    = move_player;
                    off_d   = int'(move_x) >= MAP_W || int'(move_y) >= MAP_H;
                    state_d = MS_CHECK;
                end
            end
            MS_CHECK: begin
                a_en    = !off_q;
                a_addr  = off_q ? '0 : cell_addr(tx_q, ty_q);
                pend_d  = pend_q || clear_req;
                state_d = MS_COMMIT;
            end
            MS_COMMIT: begin
                rv_d    = 1'b1;
                rtile_d = pl_q;
                pend_d  = pend_q || clear_req;
                state_d = MS_IDLE;
                if (!pl_ok) begin
                    rerr_d = 1'b1;
                end else if (occ == EMPTY) begin
                    a_en    = 1'b1;
                    a_we    = 1'b1;
                    a_addr  = cell_addr(tx_q, ty_q);
                    a_wdata = pl_q;
                end else begin
                    rhit_d  = 1'b1;
                    rtile_d = occ;
                end
            end
        endcase

        busy_d   = state_d == MS_CLEAR;
        ready_d  = state_d == MS_IDLE && !pend_d;
        rd_off_d = int'(rd_x) >= MAP_W || int'(rd_y) >= MAP_H;
        b_addr   = rd_off_d ? '0 : cell_addr(rd_x, rd_y);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= MS_CLEAR;
            cx_q     <= '0;
            cy_q     <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            pl_q     <= '0;
            off_q    <= 1'b0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            rv_q     <= 1'b0;
            rhit_q   <= 1'b0;
            rerr_q   <= 1'b0;
            rtile_q  <= '0;
            rd_off_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            pl_q     <= pl_d;
            off_q    <= off_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            rv_q     <= rv_d;
            rhit_q   <= rhit_d;
            rerr_q   <= rerr_d;
            rtile_q  <= rtile_d;
            rd_off_q <= rd_off_d;
        end
    end

    assign clear_busy   = busy_q;
    assign move_ready   = ready_q;
    assign result_valid = rv_q;
    assign result_hit   = rhit_q;
    assign result_err   = rerr_q;
    assign result_tile  = rtile_q;
    assign rd_tile      = rd_off_q ? EMPTY : b_rdata;

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Bench for tile_map_ctrl: directed scenarios plus random moves against a 2-D array map model.
module tb_tile_map_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear_req = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move_player = '0;
    logic [6:0] move_x = '0;
    logic [6:0] move_y = '0;
    logic [6:0] rd_x = '0;
    logic [6:0] rd_y = '0;
    logic       clear_busy, move_ready, result_valid, result_hit, result_err;
    logic [1:0] result_tile, rd_tile;

    int vectors = 0;
    int miscompares = 0;
    int model [64][48];

    tile_map_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move_player (move_player),
        .move_x      (move_x),
        .move_y      (move_y),
        .result_valid(result_valid),
        .result_hit  (result_hit),
        .result_tile (result_tile),
        .result_err  (result_err),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_tile     (rd_tile)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 48; y++)
                model[x][y] = (x == 0 || y == 0 || x == 63 || y == 47) ? 3 : 0;
    endfunction

    function automatic int model_rd(input int x, input int y);
        return (x >= 64 || y >= 48) ? 0 : model[x][y];
    endfunction

    function automatic void model_move(input int p, input int x, input int y,
                                       output int eh, output int et, output int ee);
        int occ;
        occ = (x >= 64 || y >= 48) ? 3 : model[x][y];
        eh = 0; et = p; ee = 0;
        if (p < 1 || p > 2) ee = 1;
        else if (occ == 0) model[x][y] = p;
        else begin eh = 1; et = occ; end
    endfunction

    task automatic read_tile(input int x, input int y, output int t);
        rd_x = 7'(x);
        rd_y = 7'(y);
        @(negedge clk);
        t = int'(rd_tile);
    endtask

    task automatic do_move(input int p, input int x, input int y, output int ok,
                           output int early, output int rv, output int hit,
                           output int tile, output int err);
        int n = 0;
        ok = 0; early = 0; rv = 0; hit = 0; tile = 0; err = 0;
        while (!move_ready && n < 100) begin @(negedge clk); n++; end
        if (!move_ready) return;
        ok = 1;
        move_valid = 1'b1;
        move_player = 2'(p);
        move_x = 7'(x);
        move_y = 7'(y);
        @(negedge clk);
        move_valid = 1'b0;
        early = int'(result_valid);
        @(negedge clk);
        early = early | int'(result_valid);
        @(negedge clk);
        rv = int'(result_valid);
        hit = int'(result_hit);
        tile = int'(result_tile);
        err = int'(result_err);
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while (clear_busy && n < 5000) begin n++; @(negedge clk); end
    endtask

    task automatic test_reset();
        int n, t;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({clear_busy, move_ready, result_valid, result_hit, result_err,
             result_tile, rd_tile} !== 9'b100000000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {clear_busy, move_ready, result_valid, result_hit, result_err,
                      result_tile, rd_tile}, 9'b100000000);
        end
        rst = 1'b1;
        count_sweep(n);
        vectors++;
        if (n != 3072 || move_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL init_sweep: busy %0d cycles ready %b, expected 3072 and 1", n, move_ready);
        end
        model_clear();
        for (int i = 0; i < 19; i++) begin
            int x, y;
            if (i == 0) begin x = 0; y = 0; end
            else if (i == 1) begin x = 63; y = 47; end
            else if (i == 2) begin x = 5; y = 5; end
            else begin x = $urandom_range(0, 70); y = $urandom_range(0, 52); end
            read_tile(x, y, t);
            vectors++;
            if (t != model_rd(x, y)) begin
                miscompares++;
                $display("FAIL init_rd(%0d,%0d): got %0d expected %0d", x, y, t, model_rd(x, y));
            end
        end
    endtask

    task automatic test_directed_moves();
        int p [6] = '{1, 2, 2, 1, 3, 0};
        int x [6] = '{10, 10, 0, 64, 20, 21};
        int y [6] = '{10, 10, 7, 0, 20, 21};
        int ok, early, rv, hit, tile, err, eh, et, ee, t;
        for (int i = 0; i < 6; i++) begin
            do_move(p[i], x[i], y[i], ok, early, rv, hit, tile, err);
            model_move(p[i], x[i], y[i], eh, et, ee);
            vectors++;
            if (!ok || early != 0 || rv != 1 || err != ee || (ee == 0 && (hit != eh || tile != et))) begin
                miscompares++;
                $display("FAIL move%0d p%0d (%0d,%0d): ok %0d early %0d rv %0d hit %0d tile %0d err %0d, expected rv 1 hit %0d tile %0d err %0d",
                         i, p[i], x[i], y[i], ok, early, rv, hit, tile, err, eh, et, ee);
            end
            if (x[i] < 64) begin
                read_tile(x[i], y[i], t);
                vectors++;
                if (t != model_rd(x[i], y[i])) begin
                    miscompares++;
                    $display("FAIL move%0d_rd: got %0d expected %0d", i, t, model_rd(x[i], y[i]));
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL result_pulse: got %b expected 0", result_valid);
        end
    endtask

    task automatic test_random_moves();
        int ok, early, rv, hit, tile, err, eh, et, ee, t, p, x, y;
        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(0, 3);
            x = $urandom_range(0, 66);
            y = $urandom_range(0, 50);
            do_move(p, x, y, ok, early, rv, hit, tile, err);
            model_move(p, x, y, eh, et, ee);
            vectors++;
            if (!ok || early != 0 || rv != 1 || err != ee || (ee == 0 && (hit != eh || tile != et))) begin
                miscompares++;
                $display("FAIL rand_move%0d p%0d (%0d,%0d): ok %0d rv %0d hit %0d tile %0d err %0d, expected hit %0d tile %0d err %0d",
                         i, p, x, y, ok, rv, hit, tile, err, eh, et, ee);
            end
        end
        for (int i = 0; i < 30; i++) begin
            x = $urandom_range(0, 66);
            y = $urandom_range(0, 50);
            read_tile(x, y, t);
            vectors++;
            if (t != model_rd(x, y)) begin
                miscompares++;
                $display("FAIL rand_rd(%0d,%0d): got %0d expected %0d", x, y, t, model_rd(x, y));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, eh, et, ee;
        n = 0;
        while (!move_ready && n < 100) begin @(negedge clk); n++; end
        move_valid = 1'b1;
        move_player = 2'd1;
        move_x = 7'd40;
        move_y = 7'd20;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!result_valid && n < 10);
            model_move(1, 40, 20, eh, et, ee);
            vectors++;
            if (n != 3 || result_hit !== eh[0] || int'(result_tile) != et) begin
                miscompares++;
                $display("FAIL b2b%0d: gap %0d hit %b tile %0d, expected gap 3 hit %0d tile %0d",
                         k, n, result_hit, result_tile, eh, et);
            end
        end
        move_valid = 1'b0;
    endtask

    task automatic test_clear_in_check();
        int n, t, eh, et, ee;
        n = 0;
        while (!move_ready && n < 100) begin @(negedge clk); n++; end
        move_valid = 1'b1;
        move_player = 2'd2;
        move_x = 7'd30;
        move_y = 7'd30;
        @(negedge clk);
        move_valid = 1'b0;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        model_move(2, 30, 30, eh, et, ee);
        vectors++;
        if (result_valid !== 1'b1 || result_hit !== eh[0] || int'(result_tile) != et || move_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_in_check_result: rv %b hit %b tile %0d ready %b, expected 1 %0d %0d 0",
                     result_valid, result_hit, result_tile, move_ready, eh, et);
        end
        @(negedge clk);
        count_sweep(n);
        vectors++;
        if (n != 3072) begin
            miscompares++;
            $display("FAIL clear_sweep_len: got %0d expected 3072", n);
        end
        model_clear();
        read_tile(10, 10, t);
        vectors++;
        if (t != 0) begin
            miscompares++;
            $display("FAIL cleared_rd(10,10): got %0d expected 0", t);
        end
        read_tile(30, 30, t);
        vectors++;
        if (t != 0) begin
            miscompares++;
            $display("FAIL cleared_rd(30,30): got %0d expected 0", t);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int ok, early, rv, hit, tile, err, n, t;
        do_move(1, 7, 7, ok, early, rv, hit, tile, err);
        do_move(2, 40, 40, ok, early, rv, hit, tile, err);
        vectors++;
        if (!ok || rv != 1 || hit != 0 || tile != 2) begin
            miscompares++;
            $display("FAIL pre_sweep_move: rv %0d hit %0d tile %0d, expected 1 0 2", rv, hit, tile);
        end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (998) @(negedge clk);
        read_tile(7, 7, t);
        vectors++;
        if (t != 0) begin
            miscompares++;
            $display("FAIL midsweep_rd(7,7): got %0d expected 0", t);
        end
        read_tile(40, 40, t);
        vectors++;
        if (t != 2) begin
            miscompares++;
            $display("FAIL midsweep_rd(40,40): got %0d expected 2", t);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (clear_busy !== 1'b1 || move_ready !== 1'b0 || rd_tile !== 2'd0) begin
            miscompares++;
            $display("FAIL midsweep_reset: busy %b ready %b rd %0d, expected 1 0 0", clear_busy, move_ready, rd_tile);
        end
        rst = 1'b1;
        count_sweep(n);
        vectors++;
        if (n != 3072) begin
            miscompares++;
            $display("FAIL resweep_len: got %0d expected 3072", n);
        end
        model_clear();
        read_tile(40, 40, t);
        vectors++;
        if (t != 0) begin
            miscompares++;
            $display("FAIL resweep_rd(40,40): got %0d expected 0", t);
        end
        read_tile(0, 5, t);
        vectors++;
        if (t != 3) begin
            miscompares++;
            $display("FAIL resweep_rd(0,5): got %0d expected 3", t);
        end
    endtask

    initial begin
        test_reset();
        test_directed_moves();
        test_random_moves();
        test_back_to_back();
        test_clear_in_check();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
